// File: rtl/float_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: one shift-add step per cycle,
// then a single normalise/special-case cycle; valid/ready handshakes on both sides.
module float_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [22:0] a_man,
  input  logic [7:0]  a_exp,
  input  logic        a_sign,
  input  logic [22:0] b_man,
  input  logic [7:0]  b_exp,
  input  logic        b_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [22:0] r_man,
  output logic [7:0]  r_exp,
  output logic        r_sign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [22:0] QNAN_MAN = 23'h400000;
  localparam logic [4:0]  LAST_STEP = 5'd23;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [47:0] prod;

  logic [22:0] op_a_man;
  logic [7:0]  op_a_exp;
  logic        op_a_sign;
  logic [22:0] op_b_man;
  logic [7:0]  op_b_exp;
  logic        op_b_sign;

  logic        accept;
  logic [24:0] step_sum;

  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [9:0] e_sum;
  logic signed [9:0] e_norm;
  logic [22:0] man_norm;
  logic [22:0] res_man;
  logic [7:0]  res_exp;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    // NOTE: registered state is always assigned with <= so every flop samples
    // the pre-edge values of every other flop, independent of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default before the case so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MUL;
      end
      MUL:  if (cnt == LAST_STEP) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;

  // --------------------------------------------------------------- datapath
  // Multiplier sits in prod[23:0] and is consumed LSB first; the multiplicand
  // is added into the upper half and the whole register shifts right.
  assign step_sum = {1'b0, prod[47:24]} + (prod[0] ? {2'b01, op_a_man} : 25'd0);

  assign a_zero = (op_a_exp == 8'd0);
  assign b_zero = (op_b_exp == 8'd0);
  assign a_inf  = (op_a_exp == 8'hff) && (op_a_man == 23'd0);
  assign b_inf  = (op_b_exp == 8'hff) && (op_b_man == 23'd0);
  assign a_nan  = (op_a_exp == 8'hff) && (op_a_man != 23'd0);
  assign b_nan  = (op_b_exp == 8'hff) && (op_b_man != 23'd0);

  assign e_sum    = $signed({2'b00, op_a_exp}) + $signed({2'b00, op_b_exp}) - 10'sd127;
  assign e_norm   = prod[47] ? (e_sum + 10'sd1) : e_sum;
  assign man_norm = prod[47] ? prod[46:24] : prod[45:23];

  always_comb begin
    res_man = man_norm;
    res_exp = e_norm[7:0];
    if (a_nan || b_nan) begin
      res_exp = 8'hff;
      res_man = QNAN_MAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      res_exp = 8'hff;
      res_man = QNAN_MAN;
    end else if (a_inf || b_inf) begin
      res_exp = 8'hff;
      res_man = 23'd0;
    end else if (a_zero || b_zero) begin
      res_exp = 8'd0;
      res_man = 23'd0;
    end else if (e_norm >= 10'sd255) begin
      res_exp = 8'hff;
      res_man = 23'd0;
    end else if (e_norm <= 10'sd0) begin
      res_exp = 8'd0;
      res_man = 23'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 5'd0;
      prod      <= 48'd0;
      r_man     <= 23'd0;
      r_exp     <= 8'd0;
      r_sign    <= 1'b0;
      op_a_man  <= 23'd0;
      op_a_exp  <= 8'd0;
      op_a_sign <= 1'b0;
      op_b_man  <= 23'd0;
      op_b_exp  <= 8'd0;
      op_b_sign <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_a_man  <= a_man;
            op_a_exp  <= a_exp;
            op_a_sign <= a_sign;
            op_b_man  <= b_man;
            op_b_exp  <= b_exp;
            op_b_sign <= b_sign;
            cnt       <= 5'd0;
            prod      <= {24'd0, 1'b1, b_man};
          end
        end
        MUL: begin
          prod <= {step_sum, prod[23:1]};
          cnt  <= (cnt == LAST_STEP) ? 5'd0 : cnt + 5'd1;
        end
        NORM: begin
          r_man  <= res_man;
          r_exp  <= res_exp;
          r_sign <= op_a_sign ^ op_b_sign;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_mul_seq.sv
// Self-checking bench for float_mul_seq: directed vectors with literal results,
// plus a cycle tracker and arithmetic model compared on every falling edge.
module tb_float_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] a_man;
  logic [7:0]  a_exp;
  logic        a_sign;
  logic [22:0] b_man;
  logic [7:0]  b_exp;
  logic        b_sign;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] r_man;
  logic [7:0]  r_exp;
  logic        r_sign;

  int n_tests = 0;
  int n_fail  = 0;

  float_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_man     (a_man),
    .a_exp     (a_exp),
    .a_sign    (a_sign),
    .b_man     (b_man),
    .b_exp     (b_exp),
    .b_sign    (b_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_man     (r_man),
    .r_exp     (r_exp),
    .r_sign    (r_sign)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result word {sign, exp, man} computed with plain integer arithmetic.
  function automatic logic [31:0] model(input logic as, input logic [7:0] ae, input logic [22:0] am,
                                        input logic bs, input logic [7:0] be, input logic [22:0] bm);
    logic s;
    longint unsigned pa, pb, p;
    int e;
    logic [22:0] man;
    bit an, bn, ai, bi, az, bz;
    s  = as ^ bs;
    an = (ae == 8'hff) && (am != 0);
    bn = (be == 8'hff) && (bm != 0);
    ai = (ae == 8'hff) && (am == 0);
    bi = (be == 8'hff) && (bm == 0);
    az = (ae == 0);
    bz = (be == 0);
    if (an || bn) return {s, 8'hff, 23'h400000};
    if ((ai && bz) || (bi && az)) return {s, 8'hff, 23'h400000};
    if (ai || bi) return {s, 8'hff, 23'h0};
    if (az || bz) return {s, 8'h00, 23'h0};
    pa = {1'b1, am};
    pb = {1'b1, bm};
    p  = pa * pb;
    e  = int'(ae) + int'(be) - 127;
    if (p[47]) begin
      man = p[46:24];
      e++;
    end else begin
      man = p[45:23];
    end
    if (e >= 255) return {s, 8'hff, 23'h0};
    if (e <= 0)   return {s, 8'h00, 23'h0};
    return {s, e[7:0], man};
  endfunction

  // Cycle-level expectation: accept in idle, result 25 edges later, held until taken.
  bit          live = 1'b0;
  bit          busy = 1'b0;
  int          cyc  = 0;
  logic [31:0] exp_r = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      live <= 1'b1;
      busy <= 1'b0;
      cyc  <= 0;
    end else if (busy) begin
      if (cyc >= 25 && out_ready) busy <= 1'b0;
      else if (cyc < 25)          cyc  <= cyc + 1;
    end else if (in_valid) begin
      busy  <= 1'b1;
      cyc   <= 0;
      exp_r <= model(a_sign, a_exp, a_man, b_sign, b_exp, b_man);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("cyc_in_ready", in_ready, !busy);
      check("cyc_out_valid", out_valid, busy && cyc == 25);
      if (busy && cyc == 25) check("cyc_result", {r_sign, r_exp, r_man}, exp_r);
    end
  end

  task automatic op(input string nm,
                    input logic as, input logic [7:0] ae, input logic [22:0] am,
                    input logic bs, input logic [7:0] be, input logic [22:0] bm,
                    input logic [31:0] want, input int hold);
    int m;
    logic [31:0] snap;
    @(negedge clk);
    a_sign = as; a_exp = ae; a_man = am;
    b_sign = bs; b_exp = be; b_man = bm;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    // Keep in_valid asserted with different operands while busy; they must be ignored.
    a_man = ~am; b_exp = ~be; a_sign = ~as;
    m = 0;
    while (!out_valid && m < 40) begin
      @(posedge clk);
      m++;
      #1;
    end
    in_valid = 1'b0;
    check({nm, "_latency"}, m, 25);
    check({nm, "_result"}, {r_sign, r_exp, r_man}, want);
    snap = {r_sign, r_exp, r_man};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({nm, "_hold_result"}, {r_sign, r_exp, r_man}, snap);
      check({nm, "_hold_valid"}, out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({nm, "_ready_after"}, in_ready, 1'b1);
    check({nm, "_valid_after"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_man = '0; a_exp = '0; a_sign = 1'b0;
    b_man = '0; b_exp = '0; b_sign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", {r_sign, r_exp, r_man}, 32'd0);
    rst = 1'b0;

    // Literal pins on the model itself.
    check("pin_model_1p5x2", model(0, 8'd127, 23'h400000, 0, 8'd128, 23'h0), 32'h40400000);
    check("pin_model_1p5x1p5", model(0, 8'd127, 23'h400000, 0, 8'd127, 23'h400000), 32'h40100000);
    check("pin_model_infx0", model(0, 8'hff, 23'h0, 0, 8'h00, 23'h0), 32'h7fc00000);

    op("mul_1p5x2",    0, 8'd127, 23'h400000, 0, 8'd128, 23'h000000, 32'h40400000, 0);
    op("mul_m2x3",     1, 8'd128, 23'h000000, 0, 8'd128, 23'h400000, 32'hc0c00000, 0);
    op("mul_1p5x1p5",  0, 8'd127, 23'h400000, 0, 8'd127, 23'h400000, 32'h40100000, 0);
    op("mul_trunc",    0, 8'd127, 23'h7fffff, 0, 8'd127, 23'h7fffff, 32'h407ffffe, 0);
    op("ovf_254x254",  0, 8'd254, 23'h000000, 0, 8'd254, 23'h000000, 32'h7f800000, 0);
    op("unf_1x1",      0, 8'd1,   23'h000000, 0, 8'd1,   23'h000000, 32'h00000000, 0);
    op("exp_254",      0, 8'd190, 23'h000000, 0, 8'd191, 23'h000000, 32'h7f000000, 0);
    op("exp_norm_255", 0, 8'd190, 23'h400000, 0, 8'd191, 23'h400000, 32'h7f800000, 0);
    op("exp_1",        0, 8'd1,   23'h000000, 0, 8'd127, 23'h000000, 32'h00800000, 0);
    op("exp_0",        0, 8'd1,   23'h000000, 0, 8'd126, 23'h000000, 32'h00000000, 0);
    op("inf_x_zero",   1, 8'hff,  23'h000000, 0, 8'h00,  23'h000000, 32'hffc00000, 0);
    op("nan_x_one",    0, 8'hff,  23'h000001, 0, 8'd127, 23'h000000, 32'h7fc00000, 0);
    op("zero_x_five",  1, 8'h00,  23'h000000, 0, 8'd129, 23'h200000, 32'h80000000, 0);
    op("inf_x_inf",    1, 8'hff,  23'h000000, 1, 8'hff,  23'h000000, 32'h7f800000, 0);
    op("backpressure", 1, 8'd127, 23'h200000, 0, 8'd129, 23'h000000, 32'hc0a00000, 10);

    // Reset during the 12th MUL cycle aborts the operation.
    @(negedge clk);
    a_sign = 0; a_exp = 8'd128; a_man = 23'h400000;
    b_sign = 1; b_exp = 8'd128; b_man = 23'h400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_result", {r_sign, r_exp, r_man}, 32'd0);
    op("after_abort", 0, 8'd127, 23'h400000, 0, 8'd128, 23'h000000, 32'h40400000, 0);

    // in_valid seen on a reset edge is not an accept.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_no_accept", in_ready, 1'b1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
